// File: rtl/l2_pkg.sv
// rtl/l2_pkg.sv - widths, state encoding and datapath types for the vector sum-of-squares controller
package l2_pkg;

    localparam int DATA_W = 8;
    localparam int LEN_W  = 8;
    localparam int ACC_W  = 2 * DATA_W + LEN_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

    typedef logic [DATA_W-1:0]   elem_t;
    typedef logic [LEN_W-1:0]    len_t;
    typedef logic [ACC_W-1:0]    acc_t;
    typedef logic [2*DATA_W-1:0] sq_t;

endpackage

// File: rtl/l2_sq_accum.sv
// rtl/l2_sq_accum.sv - element register, squarer and clearable accumulator
module l2_sq_accum
    import l2_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_reset,
    input  logic  i_load,
    input  elem_t i_data,
    input  logic  i_clear,
    input  logic  i_acc_en,
    output acc_t  o_acc
);

    elem_t r_elem;
    acc_t  r_acc;
    sq_t   w_sq;

    assign w_sq = r_elem * r_elem;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_elem <= '0;
        end else if (i_load) begin
            r_elem <= i_data;
        end
    end

    // Accumulator is wide enough for a full-length vector of max values, so no wrap guard.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_acc_en) begin
            r_acc <= r_acc + ACC_W'(w_sq);
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/l2_vector_ctrl.sv
// rtl/l2_vector_ctrl.sv - frames a byte stream into vectors and emits each vector's sum of squares
module l2_vector_ctrl
    import l2_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_reset,
    input  logic  i_start,
    input  len_t  i_len,
    input  elem_t i_a,
    input  logic  i_valid_in,
    output logic  o_ready_in,
    output acc_t  o_f,
    output logic  o_valid_out,
    input  logic  i_ready_out,
    output logic  o_busy
);

    localparam len_t LEN_ONE = len_t'(1);

    state_e r_state;
    len_t   r_len;
    len_t   r_cnt;
    logic   r_mac_en;

    logic   w_accept;
    logic   w_last;
    logic   w_clear;
    acc_t   w_acc;

    assign o_ready_in  = (r_state == ST_ACCUM);
    assign o_valid_out = (r_state == ST_OUT);
    assign o_busy      = (r_state != ST_IDLE);
    assign o_f         = w_acc;

    assign w_accept = i_valid_in && o_ready_in;
    assign w_last   = (r_cnt == r_len - LEN_ONE);
    assign w_clear  = (r_state == ST_IDLE) && i_start;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= ST_IDLE;
            r_len    <= '0;
            r_cnt    <= '0;
            r_mac_en <= 1'b0;
        end else begin
            // Square of an element is summed one edge after it is registered.
            r_mac_en <= w_accept;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_cnt <= '0;
                        if (i_len != '0) begin
                            r_len   <= i_len;
                            r_state <= ST_ACCUM;
                        end else begin
                            r_state <= ST_OUT;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + LEN_ONE;
                        if (w_last) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    r_state <= ST_OUT;
                end
                ST_OUT: begin
                    if (i_ready_out) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    l2_sq_accum u_sq_accum (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_load   (w_accept),
        .i_data   (i_a),
        .i_clear  (w_clear),
        .i_acc_en (r_mac_en),
        .o_acc    (w_acc)
    );

endmodule

// File: tb/tb_l2_vector_ctrl.sv
// tb/tb_l2_vector_ctrl.sv - scoreboard bench for l2_vector_ctrl
module tb_l2_vector_ctrl;
    import l2_pkg::*;

    logic  clk;
    logic  reset;
    logic  start;
    len_t  len;
    elem_t a;
    logic  valid_in;
    logic  ready_in;
    acc_t  f;
    logic  valid_out;
    logic  ready_out;
    logic  busy;

    int n_checks = 0;
    int n_fail   = 0;

    int exp_q[$];
    int v_elems[$];

    logic hold_prev = 1'b0;
    acc_t prev_f    = '0;

    l2_vector_ctrl dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_start     (start),
        .i_len       (len),
        .i_a         (a),
        .i_valid_in  (valid_in),
        .o_ready_in  (ready_in),
        .o_f         (f),
        .o_valid_out (valid_out),
        .i_ready_out (ready_out),
        .o_busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake and checks hold stability under backpressure.
    always @(negedge clk) begin
        if (hold_prev) begin
            chk("hold_valid", {31'd0, valid_out}, 32'd1);
            chk("hold_f", {8'd0, f}, {8'd0, prev_f});
        end
        hold_prev = 1'b0;
        if (!reset && valid_out) begin
            if (ready_out) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: actual f=%0d required no output", f);
                end else begin
                    chk("f", {8'd0, f}, exp_q.pop_front());
                end
            end else begin
                hold_prev = 1'b1;
                prev_f    = f;
            end
        end
    end

    task automatic do_start(input int n);
        start = 1'b1;
        len   = len_t'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
        len   = len_t'($urandom);
        if (n != 0) begin
            chk("start_busy", {31'd0, busy}, 32'd1);
            chk("start_ready_in", {31'd0, ready_in}, 32'd1);
            chk("start_f_cleared", {8'd0, f}, 32'd0);
        end else begin
            chk("zero_len_valid", {31'd0, valid_out}, 32'd1);
            chk("zero_len_f", {8'd0, f}, 32'd0);
        end
    endtask

    task automatic feed_elem(input int value, input int gap);
        valid_in = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        chk("accum_ready_in", {31'd0, ready_in}, 32'd1);
        chk("accum_busy", {31'd0, busy}, 32'd1);
        valid_in = 1'b1;
        a        = elem_t'(value);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        a        = elem_t'($urandom);
    endtask

    task automatic finish_out(input int hold, input bit pulse);
        ready_out = 1'b0;
        for (int h = 0; h < hold; h++) begin
            start = pulse && (h == 1);
            len   = 8'd7;
            @(posedge clk);
            #1;
            chk("bp_valid", {31'd0, valid_out}, 32'd1);
            chk("bp_busy", {31'd0, busy}, 32'd1);
        end
        start     = pulse;
        ready_out = 1'b1;
        @(posedge clk);
        #1;
        ready_out = 1'b0;
        start     = 1'b0;
        chk("post_hs_valid", {31'd0, valid_out}, 32'd0);
        chk("post_hs_busy", {31'd0, busy}, 32'd0);
        chk("post_hs_ready_in", {31'd0, ready_in}, 32'd0);
    endtask

    // Reference: expected result is the plain sum of squares of the elements in v_elems.
    task automatic run_vector(input int gap_mode, input int hold, input bit pulse);
        int sum = 0;
        foreach (v_elems[i]) sum += v_elems[i] * v_elems[i];
        exp_q.push_back(sum);
        do_start(v_elems.size());
        if (v_elems.size() != 0) begin
            foreach (v_elems[i]) begin
                feed_elem(v_elems[i], (i == 0) ? 0 :
                          (gap_mode >= 0 ? gap_mode : int'($urandom_range(0, 2))));
            end
            chk("drain_ready_in", {31'd0, ready_in}, 32'd0);
            chk("drain_valid", {31'd0, valid_out}, 32'd0);
            @(posedge clk);
            #1;
            chk("latency_valid", {31'd0, valid_out}, 32'd1);
            chk("out_ready_in", {31'd0, ready_in}, 32'd0);
        end
        finish_out(hold, pulse);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        len       = '0;
        a         = '0;
        valid_in  = 1'b0;
        ready_out = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready_in", {31'd0, ready_in}, 32'd0);
        chk("rst_valid_out", {31'd0, valid_out}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_f", {8'd0, f}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        v_elems = '{1, 2, 3, 4};
        run_vector(0, 0, 1'b0);

        v_elems.delete();
        for (int i = 0; i < 255; i++) v_elems.push_back(255);
        run_vector(0, 1, 1'b0);

        v_elems = '{10, 0, 7};
        run_vector(2, 0, 1'b0);

        v_elems.delete();
        run_vector(0, 0, 1'b0);

        v_elems = '{9, 200, 33};
        run_vector(1, 5, 1'b1);

        do_start(5);
        feed_elem(3, 0);
        feed_elem(3, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_valid", {31'd0, valid_out}, 32'd0);
        chk("abort_ready_in", {31'd0, ready_in}, 32'd0);
        chk("abort_f", {8'd0, f}, 32'd0);
        v_elems = '{3, 4};
        run_vector(0, 0, 1'b0);

        do_start(2);
        feed_elem(5, 0);
        feed_elem(6, 0);
        @(posedge clk);
        #1;
        chk("rst_out_pre_valid", {31'd0, valid_out}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_out_valid", {31'd0, valid_out}, 32'd0);
        chk("rst_out_f", {8'd0, f}, 32'd0);
        chk("rst_out_busy", {31'd0, busy}, 32'd0);
        ready_out = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("rst_out_quiet", {31'd0, valid_out}, 32'd0);
        end
        ready_out = 1'b0;

        for (int v = 0; v < 12; v++) begin
            int n;
            v_elems.delete();
            n = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 16));
            for (int i = 0; i < n; i++) v_elems.push_back(int'($urandom_range(0, 255)));
            run_vector(-1, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
